// File: rtl/midi_tx.sv
// MIDI transmit path: turns note on/off events into channel-voice messages
// (status, note, velocity) with optional running status, and shifts them out
// as back-to-back 8N1 UART frames on o_tx.
module midi_tx #(
  parameter int BAUD_DIV       = 233,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_note_on,
  input  logic [3:0] i_ch,
  input  logic [6:0] i_note_num,
  input  logic [6:0] i_velocity,
  input  logic       i_rs_clear,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_msg_done
);

  localparam int                CNT_W      = (BAUD_DIV < 1) ? 1 : $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_DIV);
  localparam logic [3:0]       LAST_BIT   = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_STAT = 3'd1,
    ST_SEND_D1   = 3'd2,
    ST_SEND_D2   = 3'd3,
    ST_DONE      = 3'd4
  } msg_state_e;

  // Line level for frame position idx: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic tx_bit(input logic [7:0] b, input logic [3:0] idx);
    logic r;
    case (idx)
      4'd0:    r = 1'b0;
      4'd1:    r = b[0];
      4'd2:    r = b[1];
      4'd3:    r = b[2];
      4'd4:    r = b[3];
      4'd5:    r = b[4];
      4'd6:    r = b[5];
      4'd7:    r = b[6];
      4'd8:    r = b[7];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Byte sequence order once the current byte has finished.
  function automatic msg_state_e next_send(input msg_state_e s);
    msg_state_e r;
    case (s)
      ST_SEND_STAT: r = ST_SEND_D1;
      ST_SEND_D1:   r = ST_SEND_D2;
      ST_SEND_D2:   r = ST_DONE;
      default:      r = ST_IDLE;
    endcase
    return r;
  endfunction

  msg_state_e       state_q, state_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       status_q, status_d;
  logic [7:0]       d1_q, d1_d;
  logic [7:0]       d2_q, d2_d;
  logic [7:0]       last_status_q, last_status_d;
  logic             rs_flag_q, rs_flag_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_s;
  logic             bit_end_s;
  logic             stat_done_s;
  logic             skip_stat_s;
  logic [7:0]       new_status_s;
  logic [7:0]       byte_s;

  assign accept_s     = i_valid & ready_q;
  assign bit_end_s    = (cnt_q == '0);
  assign stat_done_s  = (state_q == ST_SEND_STAT) && bit_end_s && (bit_idx_q == LAST_BIT);
  assign new_status_s = {1'b1, 2'b00, i_note_on, i_ch};
  // A pending or simultaneous rs_clear always forces the status byte out.
  assign skip_stat_s  = (RUNNING_STATUS != 0) && (new_status_s == last_status_q) &&
                        !rs_flag_q && !i_rs_clear;

  // Message sequencing, bit timing, running-status bookkeeping and next outputs.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    cnt_d         = cnt_q;
    status_d      = status_q;
    d1_d          = d1_q;
    d2_d          = d2_q;
    last_status_d = last_status_q;
    rs_flag_d     = rs_flag_q;
    byte_s        = 8'hFF;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          status_d  = new_status_s;
          d1_d      = {1'b0, i_note_num};
          d2_d      = {1'b0, i_velocity};
          bit_idx_d = 4'd0;
          cnt_d     = CNT_RELOAD;
          if (skip_stat_s) begin
            state_d = ST_SEND_D1;
          end else begin
            state_d = ST_SEND_STAT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_STAT, ST_SEND_D1, ST_SEND_D2: begin
        if (bit_end_s) begin
          cnt_d = CNT_RELOAD;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = 4'd0;
            state_d   = next_send(state_q);
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stat_done_s) begin
      last_status_d = status_q;
    end else begin
      last_status_d = last_status_q;
    end

    // A new request wins over the clear from a completing status byte.
    if (i_rs_clear) begin
      rs_flag_d = 1'b1;
    end else if (stat_done_s) begin
      rs_flag_d = 1'b0;
    end else begin
      rs_flag_d = rs_flag_q;
    end

    case (state_d)
      ST_SEND_STAT: byte_s = status_d;
      ST_SEND_D1:   byte_s = d1_d;
      ST_SEND_D2:   byte_s = d2_d;
      default:      byte_s = 8'hFF;
    endcase
  end

  assign ready_d = (state_d == ST_IDLE);
  assign busy_d  = (state_d == ST_SEND_STAT) || (state_d == ST_SEND_D1) || (state_d == ST_SEND_D2);
  assign done_d  = (state_d == ST_DONE);
  assign tx_d    = busy_d ? tx_bit(byte_s, bit_idx_d) : 1'b1;

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q       <= ST_IDLE;
      bit_idx_q     <= 4'd0;
      cnt_q         <= '0;
      status_q      <= 8'h00;
      d1_q          <= 8'h00;
      d2_q          <= 8'h00;
      last_status_q <= 8'h00;
      rs_flag_q     <= 1'b0;
      tx_q          <= 1'b1;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      cnt_q         <= cnt_d;
      status_q      <= status_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      last_status_q <= last_status_d;
      rs_flag_q     <= rs_flag_d;
      tx_q          <= tx_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign o_tx       = tx_q;
  assign o_ready    = ready_q;
  assign o_busy     = busy_q;
  assign o_msg_done = done_q;

endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx: a reference model pushes expected bytes and
// completion latencies into queues; a UART monitor and a done monitor pop them.
module tb_midi_tx;

  localparam int BD  = 3;
  localparam int BPC = BD + 1;
  localparam int RS  = 1;

  logic       clk;
  logic       res;
  logic       valid;
  logic       ready;
  logic       note_on;
  logic [3:0] ch;
  logic [6:0] note_num;
  logic [6:0] velocity;
  logic       rs_clear;
  logic       tx;
  logic       busy;
  logic       msg_done;

  int         n_checks;
  int         n_fail;
  int         ncyc;

  logic [7:0] exp_bytes[$];
  int         done_lat[$];
  int         acc_q[$];

  logic [7:0] m_last;
  logic       m_rsf;

  logic       mon_active;
  int         mon_cnt;
  logic [7:0] mon_byte;

  midi_tx #(.BAUD_DIV(BD), .RUNNING_STATUS(RS)) dut (
    .i_clk      (clk),
    .i_res      (res),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_note_on  (note_on),
    .i_ch       (ch),
    .i_note_num (note_num),
    .i_velocity (velocity),
    .i_rs_clear (rs_clear),
    .o_tx       (tx),
    .o_busy     (busy),
    .o_msg_done (msg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one accepted event: decides on the status byte and queues expectations.
  task automatic model_accept(input logic on, input logic [3:0] c, input logic [6:0] nn,
                              input logic [6:0] vel, input logic rsc);
    logic [7:0] st;
    logic       send_st;
    st = 8'h80 | (on ? 8'h10 : 8'h00) | {4'h0, c};
    if (rsc) m_rsf = 1'b1;
    send_st = !((RS != 0) && (st == m_last) && !m_rsf);
    if (send_st) begin
      exp_bytes.push_back(st);
      m_last = st;
      m_rsf  = 1'b0;
    end
    exp_bytes.push_back({1'b0, nn});
    exp_bytes.push_back({1'b0, vel});
    done_lat.push_back(send_st ? (30 * BPC + 1) : (20 * BPC + 1));
    acc_q.push_back(ncyc);
  endtask

  // Call at negedge+1; returns at negedge+1 of the first cycle after acceptance.
  task automatic send_ev(input logic on, input logic [3:0] c, input logic [6:0] nn,
                         input logic [6:0] vel, input logic rsc);
    int n;
    n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready_wait", {31'd0, ready}, 32'd1);
    valid    = 1'b1;
    note_on  = on;
    ch       = c;
    note_num = nn;
    velocity = vel;
    rs_clear = rsc;
    model_accept(on, c, nn, vel, rsc);
    @(negedge clk); #1;
    valid    = 1'b0;
    rs_clear = 1'b0;
    chk("ready_drop", {31'd0, ready}, 32'd0);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("tx_start_latency", {31'd0, tx}, 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("idle_wait", {31'd0, ready}, 32'd1);
  endtask

  // UART frame monitor and completion-pulse checker, sampled on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (res) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        chk("start_bit", {31'd0, tx}, 32'd0);
      end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % BPC) == 2) begin
        mon_byte[(mon_cnt - 6) / BPC] = tx;
      end else if (mon_cnt == 38) begin
        chk("stop_bit", {31'd0, tx}, 32'd1);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        chk("byte_expected", {31'd0, (exp_bytes.size() > 0)}, 32'd1);
        if (exp_bytes.size() > 0) chk("tx_byte", {24'd0, mon_byte}, {24'd0, exp_bytes.pop_front()});
      end else if (mon_cnt == 39) begin
        mon_active = 1'b0;
      end
    end
    if (!res && msg_done === 1'b1) begin
      chk("done_expected", {31'd0, (done_lat.size() > 0)}, 32'd1);
      if (done_lat.size() > 0 && acc_q.size() > 0) begin
        chk("done_latency", ncyc - acc_q.pop_front(), done_lat.pop_front());
      end
      chk("busy_in_done", {31'd0, busy}, 32'd0);
      chk("ready_in_done", {31'd0, ready}, 32'd0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_t0;
    int acc_t1;
    n_checks   = 0;
    n_fail     = 0;
    ncyc       = 0;
    m_last     = 8'h00;
    m_rsf      = 1'b0;
    mon_active = 1'b0;
    mon_cnt    = 0;
    mon_byte   = 8'h00;
    res        = 1'b1;
    valid      = 1'b0;
    note_on    = 1'b0;
    ch         = 4'd0;
    note_num   = 7'd0;
    velocity   = 7'd0;
    rs_clear   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, msg_done}, 32'd0);
    res = 1'b0;
    @(negedge clk); #1;

    // Full message, then running status on the same status byte.
    send_ev(1'b1, 4'd0, 7'h3C, 7'h64, 1'b0);
    wait_idle();
    send_ev(1'b1, 4'd0, 7'h40, 7'h00, 1'b0);
    wait_idle();

    // Status changes: 90 (forced), 80, 93.
    send_ev(1'b1, 4'd0, 7'h3C, 7'h64, 1'b1);
    wait_idle();
    send_ev(1'b0, 4'd0, 7'h3C, 7'h40, 1'b0);
    wait_idle();
    send_ev(1'b1, 4'd3, 7'h3C, 7'h7F, 1'b0);
    wait_idle();

    // rs_clear during the second byte of a running-status message.
    send_ev(1'b1, 4'd3, 7'h10, 7'h20, 1'b0);
    repeat (44) begin
      @(negedge clk); #1;
    end
    rs_clear = 1'b1;
    m_rsf    = 1'b1;
    @(negedge clk); #1;
    rs_clear = 1'b0;
    wait_idle();
    send_ev(1'b1, 4'd3, 7'h11, 7'h21, 1'b0);
    wait_idle();
    send_ev(1'b1, 4'd3, 7'h12, 7'h22, 1'b0);
    wait_idle();

    // Reset during bit 3 of a status byte whose value was already sent before.
    send_ev(1'b1, 4'd5, 7'h3C, 7'h64, 1'b0);
    wait_idle();
    send_ev(1'b1, 4'd5, 7'h3C, 7'h64, 1'b1);
    repeat (17) begin
      @(negedge clk); #1;
    end
    res = 1'b1;
    @(negedge clk); #1;
    chk("midreset_tx", {31'd0, tx}, 32'd1);
    chk("midreset_ready", {31'd0, ready}, 32'd1);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, msg_done}, 32'd0);
    exp_bytes.delete();
    done_lat.delete();
    acc_q.delete();
    m_last = 8'h00;
    m_rsf  = 1'b0;
    res    = 1'b0;
    repeat (200) begin
      @(negedge clk); #1;
    end
    send_ev(1'b1, 4'd5, 7'h3C, 7'h64, 1'b0);
    wait_idle();

    // i_valid held high: one acceptance per IDLE cycle.
    valid    = 1'b1;
    note_on  = 1'b1;
    ch       = 4'd0;
    note_num = 7'h7F;
    velocity = 7'h7F;
    acc_t0   = 0;
    acc_t1   = 0;
    for (int k = 0; k < 2; k++) begin
      int n;
      n = 0;
      while (!ready && n < 2000) begin
        @(negedge clk); #1;
        n++;
      end
      chk("hold_ready", {31'd0, ready}, 32'd1);
      if (k == 0) acc_t0 = ncyc;
      else acc_t1 = ncyc;
      model_accept(1'b1, 4'd0, 7'h7F, 7'h7F, 1'b0);
      @(negedge clk); #1;
      chk("hold_ready_drop", {31'd0, ready}, 32'd0);
    end
    valid = 1'b0;
    chk("hold_accept_gap", acc_t1 - acc_t0, 30 * BPC + 2);
    wait_idle();

    repeat (10) begin
      @(negedge clk); #1;
    end
    chk("sb_bytes_left", exp_bytes.size(), 32'd0);
    chk("sb_done_left", done_lat.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- MIDI transmit path: counterpart to the MIDI UART receive/decode chain.
- Accepts note events (on/off, channel, note number, velocity) over a valid/ready handshake.
- Encodes each event as a MIDI channel-voice message, with optional running status.
- Serialises the message bytes as 8N1 UART on a single TX pin, at the clk9m domain rate.

Parameters:
- BAUD_DIV, default 233: clocks per bit minus 1. At 9 MHz this gives 234 clocks per bit, ≈38400 bps, matching the receive side.
- RUNNING_STATUS, default 1: when 1, the status byte is omitted if it equals the last status byte sent.

Ports:
- i_clk, input, 1: system clock (9 MHz).
- i_res, input, 1: reset, synchronous, active-high.
- i_valid, input, 1: event valid.
- o_ready, output, 1: block can accept an event this cycle.
- i_note_on, input, 1: 1 = Note On (0x9n), 0 = Note Off (0x8n).
- i_ch, input, 4: MIDI channel 0-15, goes to the status low nibble.
- i_note_num, input, 7: note number, data byte 1.
- i_velocity, input, 7: velocity, data byte 2.
- i_rs_clear, input, 1: forget the last status; the next message always carries a status byte.
- o_tx, output, 1: UART TX line, idle high.
- o_busy, output, 1: a message is being transmitted.
- o_msg_done, output, 1: one-cycle pulse after the stop bit of the last byte of a message.

Behaviour:
- Reset values: o_tx=1, o_ready=1, o_busy=0, o_msg_done=0. last_status register = 0x00 (invalid). State = IDLE.
- Accept rule: an event is accepted on a cycle where i_valid & o_ready.
  - On acceptance, capture status = {1, ~i_note_on? 000 : 001, i_ch} → 0x8n or 0x9n.
  - Capture d1 = {0, i_note_num} and d2 = {0, i_velocity}. Data-byte bit 7 is forced to 0.
- o_ready = 1 only in IDLE. It drops the cycle after acceptance. Input changes while o_ready=0 are ignored.
- Message FSM: IDLE → SEND_STAT → SEND_D1 → SEND_D2 → DONE → IDLE.
  - From IDLE, go directly to SEND_D1 when RUNNING_STATUS=1 and status == last_status and no i_rs_clear is pending.
  - last_status is updated to status when SEND_STAT completes.
  - DONE lasts 1 cycle and asserts o_msg_done. o_ready returns high on the following cycle.
- Byte FSM inside each SEND state: START (o_tx=0), BIT0..BIT7 (LSB first), STOP (o_tx=1).
  - Each bit lasts exactly BAUD_DIV+1 clocks, counted by a bit-period counter that reloads at 0.
  - Bytes are sent back-to-back, with no idle gap between a stop bit and the next start bit.
- Latency: o_tx falls on the first cycle after the acceptance cycle.
  - Full message (3 bytes): 30 bit periods; o_msg_done pulses on cycle 30*(BAUD_DIV+1)+1 after acceptance.
  - Running-status message (2 bytes): 20 bit periods.
- o_busy = 1 from the cycle after acceptance through the last STOP cycle. o_busy = 0 in DONE and IDLE.
- i_rs_clear:
  - Sets a sticky flag that forces the next message to send its status byte.
  - The flag is cleared when that status byte completes.
  - Asserted mid-message, it does not alter the message in flight.
  - Asserted together with an accepted event, it applies to that event.
- RUNNING_STATUS=0: the status byte is always sent and last_status is unused.
- Reset mid-frame: on the next cycle o_tx=1 and all outputs return to reset values. last_status is invalidated. The partial byte is abandoned; no completion pulse is generated.
- Status change: Note On ch0 followed by Note Off ch0 sends the new status 0x80, because 0x80 ≠ 0x90.
- i_valid held high continuously: one event is accepted per IDLE cycle, i.e. one per DONE+1 boundary.

Test Plan (BAUD_DIV=3, i.e. 4 clocks/bit):
- Reset, then Note On ch0, note 0x3C, vel 0x64 → o_tx carries bytes 0x90, 0x3C, 0x64, each start/LSB-first/stop, 4 clocks per bit. o_msg_done pulses exactly 121 cycles after acceptance.
- Repeat the same status with note 0x40, vel 0x00 → only 0x40, 0x00 are sent (20 bit periods). o_msg_done at cycle 81.
- Send Note On ch0 0x3C/0x64, then Note Off ch0 0x3C/0x40, then Note On ch3 0x3C/0x7F → byte streams are 90 3C 64; 80 3C 40; 93 3C 7F.
- Assert i_rs_clear during the second byte of a message, then repeat that status → the status byte is resent. A third message with the same status is sent without it.
- Assert i_res during bit 3 of the status byte → o_tx=1 and o_ready=1 the following cycle, and no o_msg_done. Then resend the same event → the full 3-byte message including status is sent.
- Hold i_valid=1 with note 0x7F and velocity input 0x7F → o_ready deasserts one cycle after acceptance and the next accept is only at IDLE. All data bytes are sent with bit 7 = 0 (byte value 0x7F).
